// File: rtl/cart_mem_sequencer.sv
// Converts one mapper-qualified MSX cartridge access into a single req/ack memory transaction,
// stalling the Z80 with wait_n until data returns and driving read data until the strobe ends.
module cart_mem_sequencer #(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 63,
    parameter logic [7:0] ABORT_DATA  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cart_ena,
    input  logic        ram_ena,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [22:0] mem_addr_in,
    input  logic [7:0]  cdin,
    output logic [7:0]  cdout,
    output logic        cdout_oe,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic                   rd_s, wr_s;
    logic                   strobe_q;
    logic                   bus_idle;
    logic                   start;
    logic                   is_read;
    logic                   go;
    logic                   in_flight;
    logic                   abort;
    logic [7:0]             tmo_cnt;

    // Strobes come straight off the asynchronous MSX bus; idle level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sync  <= '1;
            wr_sync  <= '1;
            strobe_q <= 1'b1;
        end else begin
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], rd_n};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], wr_n};
            strobe_q <= bus_idle;
        end
    end

    assign rd_s      = rd_sync[SYNC_STAGES-1];
    assign wr_s      = wr_sync[SYNC_STAGES-1];
    assign bus_idle  = rd_s & wr_s;
    assign start     = cart_ena & strobe_q & ~bus_idle;
    // A cycle with both strobes low is resolved as a read.
    assign is_read   = ~rd_s;
    assign go        = (state == IDLE) & start & (is_read | ram_ena);
    assign in_flight = (state == REQ) | (state == WAIT_ACK);
    assign abort     = (state == WAIT_ACK) & ~mem_ack & (tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (go) state_next = REQ;
            REQ:      state_next = mem_ack ? HOLD : WAIT_ACK;
            WAIT_ACK: if (mem_ack || abort) state_next = HOLD;
            HOLD:     if (bus_idle) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Transaction registers; a late ack outside REQ/WAIT_ACK falls through untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdout       <= 8'h00;
            cdout_oe    <= 1'b0;
            wait_n      <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            timeout_err <= 1'b0;
            tmo_cnt     <= 8'd0;
        end else begin
            if (go) begin
                mem_addr  <= mem_addr_in;
                mem_we    <= ~is_read;
                mem_wdata <= cdin;
                wait_n    <= 1'b0;
                mem_req   <= 1'b1;
                tmo_cnt   <= 8'd0;
            end else if (in_flight && mem_ack) begin
                mem_req <= 1'b0;
                wait_n  <= 1'b1;
                if (!mem_we) begin
                    cdout    <= mem_rdata;
                    cdout_oe <= 1'b1;
                end
            end else if (abort) begin
                mem_req     <= 1'b0;
                wait_n      <= 1'b1;
                timeout_err <= 1'b1;
                if (!mem_we) begin
                    cdout    <= ABORT_DATA;
                    cdout_oe <= 1'b1;
                end
            end else if (state == WAIT_ACK) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end else if (state == HOLD && bus_idle) begin
                cdout_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_sequencer.sv
// Directed and randomized cartridge accesses checked against a transaction-level expectation model.
module tb_cart_mem_sequencer;

    localparam int TMO = 63;

    logic        clk;
    logic        reset_n;
    logic        cart_ena;
    logic        ram_ena;
    logic        rd_n;
    logic        wr_n;
    logic [22:0] mem_addr_in;
    logic [7:0]  cdin;
    logic [7:0]  cdout;
    logic        cdout_oe;
    logic        wait_n;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    bit to_flag = 0;

    cart_mem_sequencer #(
        .SYNC_STAGES(2),
        .TIMEOUT    (TMO),
        .ABORT_DATA (8'hFF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cart_ena   (cart_ena),
        .ram_ena    (ram_ena),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .mem_addr_in(mem_addr_in),
        .cdin       (cdin),
        .cdout      (cdout),
        .cdout_oe   (cdout_oe),
        .wait_n     (wait_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = read, 1 = write, 2 = both strobes low.
    // ack_dly: mem_req-high cycle index (0 = REQ cycle) in which the memory acks.
    task automatic access(input int kind, input bit cart, input bit ram,
                          input logic [22:0] addr, input logic [7:0] wd,
                          input logic [7:0] rdv, input int ack_dly);
        bit rd_op;
        bit expect_txn;
        bit tmo;
        bit req_seen;
        bit wait_bad;
        bit oe_seen;
        bit hold_bad;
        bit extra_req;
        int n;
        int c;
        int exp_c;
        logic [7:0] exp_dout;

        rd_op      = (kind != 1);
        expect_txn = cart && (rd_op || ram);
        tmo        = (ack_dly > TMO);
        exp_c      = (tmo ? TMO : ack_dly) + 1;
        exp_dout   = tmo ? 8'hFF : rdv;

        mem_addr_in = addr;
        cdin        = wd;
        cart_ena    = cart;
        ram_ena     = ram;
        rd_n        = (kind == 1);
        wr_n        = (kind == 0);

        n = 0; req_seen = 0; wait_bad = 0; oe_seen = 0; hold_bad = 0; extra_req = 0;
        while (n < 6 && !req_seen) begin
            @(negedge clk);
            n++;
            if (mem_req) req_seen = 1;
            else if (!wait_n) wait_bad = 1;
            if (cdout_oe) oe_seen = 1;
        end

        if (!expect_txn) begin
            chk("no_req", {31'd0, req_seen}, 32'd0);
            chk("no_wait", {31'd0, wait_bad}, 32'd0);
            chk("no_oe", {31'd0, oe_seen}, 32'd0);
            rd_n = 1'b1; wr_n = 1'b1;
            repeat (4) @(negedge clk);
            chk("tmo_err_idle", {31'd0, timeout_err}, {31'd0, to_flag});
            return;
        end

        chk("req_seen", {31'd0, req_seen}, 32'd1);
        chk("wait_pre", {31'd0, wait_bad}, 32'd0);
        chk("req_we", {31'd0, mem_we}, {31'd0, !rd_op});
        chk("req_addr", {9'd0, mem_addr}, {9'd0, addr});
        if (!rd_op) chk("req_wdata", {24'd0, mem_wdata}, {24'd0, wd});
        // Changing cart_ena after start must not matter.
        cart_ena = 1'b0;

        c = 0;
        while (mem_req && c < TMO + 8) begin
            if (mem_addr !== addr || wait_n !== 1'b0 || mem_we !== !rd_op) hold_bad = 1;
            if (cdout_oe) oe_seen = 1;
            mem_ack   = (c == ack_dly);
            mem_rdata = (c == ack_dly) ? rdv : 8'($urandom);
            @(negedge clk);
            c++;
            mem_ack = 1'b0;
        end
        chk("req_cycles", c, exp_c);
        chk("req_stable", {31'd0, hold_bad}, 32'd0);
        chk("wait_done", {31'd0, wait_n}, 32'd1);
        chk("oe_done", {31'd0, cdout_oe}, {31'd0, rd_op});
        if (rd_op) chk("cdout", {24'd0, cdout}, {24'd0, exp_dout});
        to_flag = to_flag | tmo;
        chk("tmo_err", {31'd0, timeout_err}, {31'd0, to_flag});

        if (tmo) begin
            mem_ack = 1'b1;
            mem_rdata = ~rdv;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("late_ack_req", {31'd0, mem_req}, 32'd0);
            chk("late_ack_wait", {31'd0, wait_n}, 32'd1);
            if (rd_op) chk("late_ack_dout", {24'd0, cdout}, 32'h0000_00FF);
        end

        repeat (2) begin
            @(negedge clk);
            if (mem_req) extra_req = 1;
            if (cdout_oe !== rd_op) hold_bad = 1;
        end
        chk("hold_oe", {31'd0, hold_bad}, 32'd0);

        rd_n = 1'b1; wr_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_req) extra_req = 1;
        end
        chk("single_req", {31'd0, extra_req}, 32'd0);
        chk("oe_release", {31'd0, cdout_oe}, 32'd0);
        if (!rd_op) chk("wr_no_oe", {31'd0, oe_seen}, 32'd0);
    endtask

    initial begin
        int k;
        bit seen;

        reset_n = 1'b0; cart_ena = 1'b0; ram_ena = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        mem_addr_in = '0; cdin = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cdout", {24'd0, cdout}, 32'd0);
        chk("rst_oe", {31'd0, cdout_oe}, 32'd0);
        chk("rst_wait", {31'd0, wait_n}, 32'd1);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {9'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        access(0, 1, 0, 23'h420123, 8'h00, 8'h5A, 3);
        access(1, 1, 1, 23'h012345, 8'hC3, 8'h00, 2);
        access(1, 1, 0, 23'h012346, 8'h3C, 8'h00, 0);
        access(0, 0, 1, 23'h7FFFFF, 8'h00, 8'h11, 1);
        access(0, 1, 0, 23'h000001, 8'h00, 8'h22, 0);
        access(0, 1, 0, 23'h000002, 8'h00, 8'h33, 1);
        access(0, 1, 0, 23'h000003, 8'h00, 8'h44, 1);
        access(2, 1, 0, 23'h155555, 8'h99, 8'h66, 2);
        access(0, 1, 1, 23'h2AAAAA, 8'h00, 8'hE7, TMO);
        access(0, 1, 0, 23'h300000, 8'h00, 8'h12, 100);
        access(1, 1, 1, 23'h300001, 8'hA5, 8'h00, TMO + 1);

        // Reset while the memory is stalled in WAIT_ACK.
        cart_ena = 1'b1; rd_n = 1'b0; mem_addr_in = 23'h0ABCDE;
        k = 0; seen = 0;
        while (k < 6 && !seen) begin
            @(negedge clk);
            k++;
            seen = mem_req;
        end
        chk("mid_req_seen", {31'd0, seen}, 32'd1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_wait", {31'd0, wait_n}, 32'd1);
        chk("mid_rst_tmo", {31'd0, timeout_err}, 32'd0);
        to_flag = 0;
        rd_n = 1'b1; cart_ena = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        access(0, 1, 0, 23'h0ABCDE, 8'h00, 8'hB4, 2);

        for (int i = 0; i < 24; i++) begin
            int kind;
            int dly;
            kind = int'($urandom_range(0, 2));
            dly  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 4))
                                                : int'($urandom_range(0, 5));
            access(kind, $urandom_range(0, 4) != 0, 1'($urandom),
                   23'($urandom), 8'($urandom), 8'($urandom), dly);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
